// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing sets (H/V tuples), colour-width defaults,
// sync-polarity constants and the colour-bar index helper.
package vga_pkg;

  localparam int CNT_W = 12;

  typedef struct packed {
    int res;
    int fp;
    int sync;
    int bp;
  } vga_axis_t;

  localparam vga_axis_t VGA_640x480_H  = '{res: 640,  fp: 16, sync: 96,  bp: 48};
  localparam vga_axis_t VGA_640x480_V  = '{res: 480,  fp: 10, sync: 2,   bp: 33};
  localparam vga_axis_t VGA_800x600_H  = '{res: 800,  fp: 40, sync: 128, bp: 88};
  localparam vga_axis_t VGA_800x600_V  = '{res: 600,  fp: 1,  sync: 4,   bp: 23};
  localparam vga_axis_t VGA_1024x768_H = '{res: 1024, fp: 24, sync: 136, bp: 160};
  localparam vga_axis_t VGA_1024x768_V = '{res: 768,  fp: 3,  sync: 6,   bp: 29};

  localparam bit SYNC_ACT_LOW  = 1'b0;
  localparam bit SYNC_ACT_HIGH = 1'b1;

  localparam int DEF_R_W = 3;
  localparam int DEF_G_W = 3;
  localparam int DEF_B_W = 2;

  // Colour-bar index: which of 8 equal-width vertical bars a column falls in.
  function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] col, input int res);
    return 3'((32'(col) * 32'd8) / 32'(res));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical). Counts
// 0..TOTAL-1 when en && carry_in, decodes active region and sync window,
// and flags the wrap so the next axis can chain off it as a carry enable.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int RES  = 1024,
  parameter int FP   = 24,
  parameter int SYNC = 136,
  parameter int BP   = 160,
  parameter bit POL  = SYNC_ACT_LOW
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             carry_in,
  output logic [CNT_W-1:0] count,
  output logic             active,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = RES + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] RES_C   = CNT_W'(RES);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(RES + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(RES + FP + SYNC);

  logic step;

  assign step   = en && carry_in;
  assign wrap   = step && (count == LAST);
  assign active = count < RES_C;
  assign sync   = ((count >= SYNC_LO) && (count < SYNC_HI)) ? POL : ~POL;

  // Axis position: advance on carry, wrap at the end of the total period
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: single-clock VGA raster generator. Emits pixel requests
// (column/row) PIPE_DLY enables ahead of the colour outputs and delays
// sync/blank to match the pixel source latency.
// Optional build macro VGA_TEST_PATTERN_EN adds input pattern_sel, which
// replaces the pixel input with 8 vertical colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_RES    = VGA_1024x768_H.res,
  parameter int H_FP     = VGA_1024x768_H.fp,
  parameter int H_SYNC   = VGA_1024x768_H.sync,
  parameter int H_BP     = VGA_1024x768_H.bp,
  parameter int V_RES    = VGA_1024x768_V.res,
  parameter int V_FP     = VGA_1024x768_V.fp,
  parameter int V_SYNC   = VGA_1024x768_V.sync,
  parameter int V_BP     = VGA_1024x768_V.bp,
  parameter bit HS_POL   = SYNC_ACT_LOW,
  parameter bit VS_POL   = SYNC_ACT_LOW,
  parameter int R_W      = DEF_R_W,
  parameter int G_W      = DEF_G_W,
  parameter int B_W      = DEF_B_W,
  parameter int PIPE_DLY = 2
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  input  logic                   pix_en,
  input  logic [R_W+G_W+B_W-1:0] pixel,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                   pattern_sel,
`endif
  output logic                   req_valid,
  output logic [CNT_W-1:0]       column,
  output logic [CNT_W-1:0]       row,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   HSync,
  output logic                   VSync,
  output logic [R_W-1:0]         Red,
  output logic [G_W-1:0]         Green,
  output logic [B_W-1:0]         Blue
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 4095 || V_TOTAL > 4095 || PIPE_DLY > 7 || PIPE_DLY < 0) begin : g_param_err
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 4095 and PIPE_DLY in 0..7");
    end
  endgenerate

  logic [CNT_W-1:0] hcnt, vcnt;
  logic             h_act, v_act, h_sync, v_sync, h_wrap, v_wrap_unused;
  logic             active_c;

  vga_axis_counter #(
    .RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h_axis (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .en      (pix_en),
    .carry_in(pix_en),
    .count   (hcnt),
    .active  (h_act),
    .sync    (h_sync),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v_axis (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .en      (pix_en),
    .carry_in(h_wrap),
    .count   (vcnt),
    .active  (v_act),
    .sync    (v_sync),
    .wrap    (v_wrap_unused)
  );

  assign active_c = h_act && v_act;

  // ---- request stage (p0): registered decode of the counters ----
  logic hs_p0, vs_p0;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_p0;
`endif

  // Request outputs and the sync/blank seeds for the alignment delay line
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      req_valid   <= 1'b0;
      column      <= '0;
      row         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_p0       <= ~HS_POL;
      vs_p0       <= ~VS_POL;
`ifdef VGA_TEST_PATTERN_EN
      bar_p0      <= '0;
`endif
    end else if (pix_en) begin
      req_valid   <= active_c;
      column      <= active_c ? hcnt : '0;
      row         <= active_c ? vcnt : '0;
      line_start  <= active_c && (hcnt == '0);
      frame_start <= active_c && (hcnt == '0) && (vcnt == '0);
      hs_p0       <= h_sync;
      vs_p0       <= v_sync;
`ifdef VGA_TEST_PATTERN_EN
      bar_p0      <= active_c ? bar_index(hcnt, H_RES) : 3'd0;
`endif
    end
  end

  // ---- alignment stage (p1): PIPE_DLY-deep delay matching the pixel source ----
`ifdef VGA_TEST_PATTERN_EN
  localparam int SW = 6;
  logic [SW-1:0] stg_p0;
  assign stg_p0 = {bar_p0, req_valid, hs_p0, vs_p0};
`else
  localparam int SW = 3;
  logic [SW-1:0] stg_p0;
  assign stg_p0 = {req_valid, hs_p0, vs_p0};
`endif

  localparam logic [SW-1:0] STG_BLANK = SW'({1'b0, ~HS_POL, ~VS_POL});

  logic [SW-1:0] stg_p1;

  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign stg_p1 = stg_p0;
    end else begin : g_dly
      logic [SW-1:0] sr_p1 [PIPE_DLY];

      // Shift request-stage blank/sync state along with the pixel read latency
      always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_DLY; i++) sr_p1[i] <= STG_BLANK;
        end else if (pix_en) begin
          sr_p1[0] <= stg_p0;
          for (int i = 1; i < PIPE_DLY; i++) sr_p1[i] <= sr_p1[i-1];
        end
      end

      assign stg_p1 = sr_p1[PIPE_DLY-1];
    end
  endgenerate

  // ---- output stage (p2): registered colour, sync and blanking ----
  logic           vld_p1, hs_p1, vs_p1;
  logic [R_W-1:0] r_src;
  logic [G_W-1:0] g_src;
  logic [B_W-1:0] b_src;

  assign {vld_p1, hs_p1, vs_p1} = stg_p1[2:0];

  // Colour source select: pixel fields are {B,G,R} LSB-first
  always_comb begin
    r_src = pixel[R_W-1:0];
    g_src = pixel[R_W +: G_W];
    b_src = pixel[R_W+G_W +: B_W];
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel) begin
      r_src = {R_W{stg_p1[3]}};
      g_src = {G_W{stg_p1[4]}};
      b_src = {B_W{stg_p1[5]}};
    end
`endif
  end

  // Final registers: colour forced to 0 outside the aligned active window
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      HSync <= ~HS_POL;
      VSync <= ~VS_POL;
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end else if (pix_en) begin
      HSync <= hs_p1;
      VSync <= vs_p1;
      Red   <= vld_p1 ? r_src : '0;
      Green <= vld_p1 ? g_src : '0;
      Blue  <= vld_p1 ? b_src : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a small raster
// (H 8/2/3/3 = 16, V 4/1/2/1 = 8, PIPE_DLY 2). A frame-buffer model answers
// requests two enables later with pixel = column + row*16 (0xFF when idle).
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic        req_valid;
    logic [11:0] column;
    logic [11:0] row;
    logic        line_start;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
  } obs_t;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_en  = 1'b0;
  logic [7:0]  pixel;
  logic        req_valid, line_start, frame_start, HSync, VSync;
  logic [11:0] column, row;
  logic [2:0]  Red, Green;
  logic [1:0]  Blue;
`ifdef VGA_TEST_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif

  vga_timing_gen #(
    .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .R_W(3), .G_W(3), .B_W(2), .PIPE_DLY(2)
  ) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .pix_en     (pix_en),
    .pixel      (pixel),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .req_valid  (req_valid),
    .column     (column),
    .row        (row),
    .line_start (line_start),
    .frame_start(frame_start),
    .HSync      (HSync),
    .VSync      (VSync),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue)
  );

  always #5 vga_clk = ~vga_clk;

  // Frame-buffer model with a two-enable read latency
  logic [7:0] fb_d0 = 8'hFF, fb_d1 = 8'hFF;
  always @(posedge vga_clk) begin
    if (!reset_n) begin
      fb_d0 <= 8'hFF;
      fb_d1 <= 8'hFF;
    end else if (pix_en) begin
      fb_d0 <= req_valid ? 8'(column + (row << 4)) : 8'hFF;
      fb_d1 <= fb_d0;
    end
  end
  assign pixel = fb_d1;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  int    e_cnt   = 0;
  int    cyc     = 0;
  obs_t  exp_cur;

  function automatic obs_t rst_obs();
    obs_t o;
    o = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    return o;
  endfunction

  // Expected outputs after the e-th enabled edge since reset release.
  // Request fields show raster position e-1; colour/sync show position e-4
  // (1 request register + 2 latency stages + 1 output register).
  function automatic obs_t model(input int e, input bit psel);
    obs_t     o;
    int       p, h, v, val;
    bit [2:0] hb;
    o = rst_obs();
    p = (e - 1) % 128;
    h = p % 16;
    v = p / 16;
    if (h < 8 && v < 4) begin
      o.req_valid   = 1'b1;
      o.column      = 12'(h);
      o.row         = 12'(v);
      o.line_start  = (h == 0);
      o.frame_start = (h == 0) && (v == 0);
    end
    if (e >= 4) begin
      p = (e - 4) % 128;
      h = p % 16;
      v = p / 16;
      o.hsync = !(h >= 10 && h < 13);   // sync window [H_RES+H_FP, +H_SYNC)
      o.vsync = !(v >= 5 && v < 7);     // sync window [V_RES+V_FP, +V_SYNC)
      if (h < 8 && v < 4) begin
        if (psel) begin
          hb      = 3'(h);
          o.red   = {3{hb[0]}};
          o.green = {3{hb[1]}};
          o.blue  = {2{hb[2]}};
        end else begin
          val     = h + v * 16;
          o.red   = 3'(val);
          o.green = 3'(val >> 3);
          o.blue  = 2'(val >> 6);
        end
      end
    end
    return o;
  endfunction

  // Drive one cycle and push the response expected after its rising edge
  task automatic step(input logic rn, input logic en, input bit ps, input string tag);
    @(negedge vga_clk);
    reset_n = rn;
    pix_en  = en;
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = ps;
`endif
    if (!rn) begin
      e_cnt   = 0;
      exp_cur = rst_obs();
    end else if (en) begin
      e_cnt   = e_cnt + 1;
      exp_cur = model(e_cnt, ps);
    end
    exp_q.push_back(exp_cur);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  initial begin
    obs_t  act, ex;
    string tg;
    forever begin
      @(posedge vga_clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        tg = tag_q.pop_front();
        act.req_valid   = req_valid;
        act.column      = column;
        act.row         = row;
        act.line_start  = line_start;
        act.frame_start = frame_start;
        act.hsync       = HSync;
        act.vsync       = VSync;
        act.red         = Red;
        act.green       = Green;
        act.blue        = Blue;
        n_total++;
        if (act === ex) n_pass++;
        else $display("FAIL %s cycle %0d: got %h required %h (vld,col,row,ls,fs,hs,vs,r,g,b)",
                      tg, cyc, act, ex);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, including with pix_en low
    step(1'b0, 1'b0, 1'b0, "reset_en0");
    step(1'b0, 1'b1, 1'b0, "reset_en1");
    step(1'b0, 1'b1, 1'b0, "reset_en1");
    // two full frames plus pipeline tail at pix_en = 1
    for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 1'b0, "run_full_rate");
    // pix_en toggling 1-0-1-0: every output must hold on disabled cycles
    for (int i = 0; i < 260; i++) step(1'b1, (i % 2) == 0, 1'b0, "run_pix_en_toggle");
    // advance to hcnt=5, vcnt=2, then reset mid-frame
    while ((e_cnt % 128) != 37) step(1'b1, 1'b1, 1'b0, "seek_mid_frame");
    step(1'b0, 1'b1, 1'b0, "reset_mid_frame");
    for (int i = 0; i < 140; i++) step(1'b1, 1'b1, 1'b0, "restart_after_reset");
`ifdef VGA_TEST_PATTERN_EN
    for (int i = 0; i < 132; i++) step(1'b1, 1'b1, 1'b1, "pattern_bars");
`endif
    @(posedge vga_clk);
    #3;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
